// File: rtl/arb4_rr_if.sv
// rtl/arb4_rr_if.sv - request/grant bundle between the clients and arb4_rr
interface arb4_rr_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, done, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, done, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/arb4_rr.sv
// rtl/arb4_rr.sv - four-client fixed/round-robin arbiter with hold-until-release and hold-time limit
module arb4_rr #(
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  arb4_rr_if.slave bus
);
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        id_q, id_d;
  logic [1:0]        last_q, last_d;
  logic              valid_q, valid_d;
  logic              to_q, to_d;

  logic [1:0]        win;
  logic [1:0]        cand;
  logic              found;
  logic              rel_done, rel_drop, rel_hold;

  // Round-robin searches downward from last_id-1 with wrap; fixed mode always from 3.
  always_comb begin
    win   = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = (RR_MODE != 0) ? (last_q - 2'(k)) : 2'(4 - k);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign rel_done = bus.done[id_q];
  assign rel_drop = ~bus.req[id_q];
  assign rel_hold = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    last_d  = last_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          id_d    = win;
          last_d  = win;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          state_d = IDLE;
          cnt_d   = '0;
          gnt_d   = 4'b0000;
          id_d    = 2'd0;
          valid_d = 1'b0;
          // A forced release only counts as a timeout when nothing else ended the grant.
          to_d    = rel_hold && !rel_done && !rel_drop;
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      id_q    <= 2'd0;
      last_q  <= 2'd0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = to_q;
endmodule

// File: tb/tb_arb4_rr.sv
// tb/tb_arb4_rr.sv - self-checking bench for arb4_rr in round-robin and fixed-priority builds
module tb_arb4_rr;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] done = 4'b0000;
  int         checks = 0;
  int         failures = 0;

  arb4_rr_if if_rr ();
  arb4_rr_if if_fx ();

  assign if_rr.req  = req;
  assign if_rr.done = done;
  assign if_fx.req  = req;
  assign if_fx.done = done;

  arb4_rr #(.RR_MODE(1), .MAX_HOLD(HOLD)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr));
  arb4_rr #(.RR_MODE(0), .MAX_HOLD(HOLD)) dut_fx (.clk(clk), .rst_n(rst_n), .bus(if_fx));

  always #5 clk = ~clk;

  // Reference model, index 0 = fixed priority, 1 = round robin.
  int m_owner[2];
  int m_len[2];
  int m_last[2];
  bit m_to[2];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_len[m]   = 0;
      m_last[m]  = 0;
      m_to[m]    = 1'b0;
    end
  endfunction

  function automatic void model_step(int m, logic [3:0] r, logic [3:0] d);
    int  c;
    int  o;
    bit  hit;
    m_to[m] = 1'b0;
    if (m_owner[m] < 0) begin
      hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        c = (m == 1) ? (m_last[m] + 3 - k) % 4 : 3 - k;
        if (!hit && r[c]) begin
          hit = 1'b1;
          m_owner[m] = c;
          m_last[m]  = c;
          m_len[m]   = 1;
        end
      end
    end else begin
      o = m_owner[m];
      if (d[o] || !r[o]) begin
        m_owner[m] = -1;
      end else if (m_len[m] == HOLD) begin
        m_owner[m] = -1;
        m_to[m]    = 1'b1;
      end else begin
        m_len[m] = m_len[m] + 1;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(0, req, done);
    model_step(1, req, done);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({if_rr.gnt, if_rr.gnt_id, if_rr.gnt_valid, if_rr.timeout} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", {if_rr.gnt, if_rr.gnt_id, if_rr.gnt_valid, if_rr.timeout}, 8'h00);
    end
    req = 4'b0100;
    cycle();
    checks++;
    if (if_rr.gnt !== 4'b0100) begin
      failures++;
      $display("FAIL reset_pre_grant gnt=%b exp=%b", if_rr.gnt, 4'b0100);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({if_rr.gnt, if_rr.gnt_id, if_rr.gnt_valid, if_rr.timeout} !== 8'h00) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", {if_rr.gnt, if_rr.gnt_id, if_rr.gnt_valid, if_rr.timeout}, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checks++;
    if (if_rr.gnt !== 4'b0100 || if_rr.gnt_id !== 2'd2 || if_rr.gnt_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_regrant gnt=%b id=%0d valid=%b exp=0100/2/1", if_rr.gnt, if_rr.gnt_id, if_rr.gnt_valid);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 3; g++) begin
      cycle();
      checks++;
      if (if_fx.gnt_id !== 2'd3 || if_fx.gnt !== 4'b1000) begin
        failures++;
        $display("FAIL fixed_all grant=%0d id=%0d gnt=%b exp=3/1000", g, if_fx.gnt_id, if_fx.gnt);
      end
      done = 4'b1000;
      cycle();
      done = 4'b0000;
      checks++;
      if (if_fx.gnt_valid !== 1'b0) begin
        failures++;
        $display("FAIL fixed_idle valid=%b exp=0", if_fx.gnt_valid);
      end
    end
    req = 4'b0011;
    cycle();
    checks++;
    if (if_fx.gnt_id !== 2'd1 || if_fx.gnt !== 4'b0010) begin
      failures++;
      $display("FAIL fixed_0011 id=%0d gnt=%b exp=1/0010", if_fx.gnt_id, if_fx.gnt);
    end
    done = 4'b0010;
    cycle();
    done = 4'b0000;
    req  = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (if_fx.gnt_valid !== 1'b0 || if_fx.gnt !== 4'b0000) begin
        failures++;
        $display("FAIL fixed_noreq valid=%b gnt=%b exp=0/0000", if_fx.gnt_valid, if_fx.gnt);
      end
    end
  endtask

  task automatic test_rr();
    int exp_seq[5] = '{3, 2, 1, 0, 3};
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      cycle();
      checks++;
      if (if_rr.gnt_id !== 2'(exp_seq[g]) || if_rr.gnt_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_order grant=%0d id=%0d valid=%b exp=%0d/1", g, if_rr.gnt_id, if_rr.gnt_valid, exp_seq[g]);
      end
      cycle();
      done = 4'b0001 << exp_seq[g];
      cycle();
      done = 4'b0000;
      checks++;
      if (if_rr.gnt_valid !== 1'b0) begin
        failures++;
        $display("FAIL rr_idle grant=%0d valid=%b exp=0", g, if_rr.gnt_valid);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0010;
    cycle();
    for (int i = 0; i < 7; i++) begin
      cycle();
      checks++;
      if (if_rr.gnt !== 4'b0010 || if_rr.timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout_hold cycle=%0d gnt=%b to=%b exp=0010/0", i + 2, if_rr.gnt, if_rr.timeout);
      end
    end
    cycle();
    checks++;
    if (if_rr.gnt !== 4'b0000 || if_rr.timeout !== 1'b1 || if_fx.timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse gnt=%b to_rr=%b to_fx=%b exp=0000/1/1", if_rr.gnt, if_rr.timeout, if_fx.timeout);
    end
    cycle();
    checks++;
    if (if_rr.gnt !== 4'b0010 || if_rr.timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_regrant gnt=%b to=%b exp=0010/0", if_rr.gnt, if_rr.timeout);
    end
    for (int i = 0; i < 7; i++) cycle();
    done = 4'b0010;
    cycle();
    done = 4'b0000;
    checks++;
    if (if_rr.gnt !== 4'b0000 || if_rr.timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_done_coincide gnt=%b to=%b exp=0000/0", if_rr.gnt, if_rr.timeout);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 4'b0100;
    cycle();
    done = 4'b0001;
    cycle();
    done = 4'b0000;
    checks++;
    if (if_rr.gnt !== 4'b0100) begin
      failures++;
      $display("FAIL drop_foreign_done gnt=%b exp=0100", if_rr.gnt);
    end
    req = 4'b0000;
    cycle();
    checks++;
    if (if_rr.gnt !== 4'b0000 || if_rr.timeout !== 1'b0) begin
      failures++;
      $display("FAIL drop_release gnt=%b to=%b exp=0000/0", if_rr.gnt, if_rr.timeout);
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 4'b0001;
    cycle();
    req = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (if_fx.gnt !== 4'b0001) begin
        failures++;
        $display("FAIL preempt_hold cycle=%0d gnt=%b exp=0001", i, if_fx.gnt);
      end
    end
    done = 4'b0001;
    cycle();
    done = 4'b0000;
    checks++;
    if (if_fx.gnt !== 4'b0000) begin
      failures++;
      $display("FAIL preempt_idle gnt=%b exp=0000", if_fx.gnt);
    end
    cycle();
    checks++;
    if (if_fx.gnt !== 4'b1000 || if_fx.gnt_id !== 2'd3) begin
      failures++;
      $display("FAIL preempt_next gnt=%b id=%0d exp=1000/3", if_fx.gnt, if_fx.gnt_id);
    end
  endtask

  task automatic test_random();
    logic [3:0] eg;
    logic [1:0] ei;
    logic [3:0] og;
    logic [1:0] oi;
    logic       ov;
    logic       ot;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      done = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      cycle();
      for (int m = 0; m < 2; m++) begin
        eg = (m_owner[m] < 0) ? 4'b0000 : 4'(1 << m_owner[m]);
        ei = (m_owner[m] < 0) ? 2'd0 : 2'(m_owner[m]);
        og = (m == 1) ? if_rr.gnt : if_fx.gnt;
        oi = (m == 1) ? if_rr.gnt_id : if_fx.gnt_id;
        ov = (m == 1) ? if_rr.gnt_valid : if_fx.gnt_valid;
        ot = (m == 1) ? if_rr.timeout : if_fx.timeout;
        checks++;
        if (og !== eg || oi !== ei || ov !== (m_owner[m] >= 0) || ot !== m_to[m]) begin
          failures++;
          $display("FAIL random mode=%0d cyc=%0d gnt=%b id=%0d v=%b to=%b exp=%b/%0d/%b/%b",
                   m, n, og, oi, ov, ot, eg, ei, (m_owner[m] >= 0), m_to[m]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr();
    test_timeout();
    test_req_drop();
    test_no_preempt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arb4_rr.md
# arb4_rr

Four-requester arbiter that shares one downstream resource, for example a single datapath port fed by the 4-to-2 priority encoder. It supports fixed-priority or round-robin selection and a hold-until-release grant handshake. It produces a one-hot grant plus an encoded grant index. A hold-time limit forces release of a requester that never finishes, so no client can starve the others indefinitely.

## Interface
- `RR_MODE`, default 1: 1 = round-robin; 0 = fixed priority, req[3] highest, req[0] lowest.
- `MAX_HOLD`, default 8: maximum cycles a grant may stay asserted; legal range 2..255.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in 4: request per client; level-sensitive, held high while the client wants the resource.
- `done` in 4: per-client release strobe; only the bit of the current grantee is honoured.
- `gnt` out 4: one-hot grant, registered.
- `gnt_id` out 2: encoded index of the grantee; 0 when no grant.
- `gnt_valid` out 1: high whenever any gnt bit is high.
- `timeout` out 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- FSM has two states, IDLE and GRANT; reset state is IDLE.
- **IDLE:**
  - If any req bit is high at a rising edge, pick a winner, register gnt/gnt_id/gnt_valid, clear the hold counter, and enter GRANT.
  - If req == 0, stay in IDLE with outputs low.
- **Winner selection, fixed mode:** highest set index wins (3 > 2 > 1 > 0).
- **Winner selection, round-robin mode:**
  - Search order is descending with wrap, starting at (last_id − 1) mod 4. Example: last_id = 2 gives order 1, 0, 3, 2.
  - last_id updates to the winner on every grant.
  - last_id resets to 0, so the first search order after reset is 3, 2, 1, 0.
- **GRANT:**
  - Outputs are held stable.
  - The hold counter increments every cycle in GRANT. Its width is $clog2(MAX_HOLD).
- **Release conditions,** evaluated at each rising edge in GRANT:
  - (a) done[gnt_id] == 1
  - (b) req[gnt_id] == 0
  - (c) hold counter == MAX_HOLD − 1
- On release, the next state is IDLE and gnt/gnt_id/gnt_valid go to 0.
- timeout is registered high for exactly one cycle, coincident with the first IDLE cycle, only when (c) is the sole cause of release.
- If (a) or (b) coincides with (c), it is a normal release and timeout stays 0.
- done bits of non-granted clients are ignored. A done in IDLE is ignored.
- Requests that arrive while in GRANT wait; no preemption occurs, even by a higher-priority client.
- A timed-out client that keeps req high is eligible again. In round-robin mode it is searched last, so others go first.
- Reset values: gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0, state = IDLE, hold counter = 0, last_id = 0.
- rst_n low at any time, including mid-grant, clears all state and outputs immediately (asynchronously). Arbitration resumes on the first rising edge after rst_n goes high.

## Timing
- Grant latency: a request sampled high at edge N in IDLE gives gnt high after edge N.
- Release latency: a release condition sampled at edge M gives gnt low after edge M.
- There is always exactly one idle cycle between consecutive grants, so a client with req held high sees gnt low for one cycle.
- Minimum grant length is 1 cycle, when done is high at the first edge in GRANT.
- Maximum grant length is exactly MAX_HOLD cycles.
- Steady-state throughput with continuous contention: one grant per (hold + 1) cycles.
- Outputs are glitch-free and are functions of registers only.
- No combinational path from req/done to any output.

## Test plan
- **Reset:**
  - Stimulus: assert rst_n = 0 mid-grant with req = 4'b0100.
  - Response: gnt, gnt_id, gnt_valid, timeout go to 0 immediately, without waiting for a clock edge.
  - After release of reset: gnt = 4'b0100 one edge later.
- **Fixed priority (RR_MODE = 0):**
  - Stimulus: req = 4'b1111 with done pulsed each grant.
  - Response: grant sequence is 3, 3, 3…
  - Stimulus: req = 4'b0011.
  - Response: gnt_id = 1.
  - Stimulus: req = 4'b0000.
  - Response: gnt_valid stays 0.
- **Round-robin fairness (RR_MODE = 1):**
  - Stimulus: req = 4'b1111 held, with done pulsed 2 cycles into each grant.
  - Response: gnt_id sequence is 3, 2, 1, 0, 3, with one idle cycle between grants.
- **Timeout (MAX_HOLD = 8):**
  - Stimulus: req = 4'b0010 held, done never asserted.
  - Response: gnt = 4'b0010 for exactly 8 cycles, then gnt = 0 with timeout = 1 for one cycle, then regrant.
  - Stimulus: same, but done asserted on cycle 8.
  - Response: timeout = 0.
- **Release by request drop:**
  - Stimulus: client 2 is granted, then req[2] is dropped while done = 0.
  - Response: gnt goes low one edge later, with timeout = 0.
  - Stimulus: done[0] pulsed while client 2 is granted.
  - Response: ignored; the grant holds.
- **No preemption:**
  - Stimulus: client 0 is granted in fixed mode, then req[3] rises.
  - Response: gnt stays 4'b0001 until done[0].
  - Following that: one idle cycle, then gnt = 4'b1000.
